// File: rtl/z80_dma_bus_master_if.sv
// Shared memory bus and CPU BUSRQ/BUSAK handshake seen by the Z80 DMA bus master.
interface z80_dma_bus_master_if;
  logic        busrq_n;
  logic        busak_n;
  logic        bus_oe;
  logic [15:0] mem_a;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  logic        mem_mreq_n;
  logic        mem_rd_n;
  logic        mem_wr_n;

  modport master (
    output busrq_n, bus_oe, mem_a, mem_do, mem_mreq_n, mem_rd_n, mem_wr_n,
    input  busak_n, mem_di
  );

  modport slave (
    input  busrq_n, bus_oe, mem_a, mem_do, mem_mreq_n, mem_rd_n, mem_wr_n,
    output busak_n, mem_di
  );
endinterface

// File: rtl/z80_dma_bus_master.sv
// Secondary Z80 bus master: borrows the memory bus via BUSRQ/BUSAK and runs block copies.
// Define Z80_DMA_FILL_EN to honour fill_mode/fill_val (single-cycle fill writes).
module z80_dma_bus_master #(
  parameter int BURST   = 0,
  parameter int REL_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          src_addr,
  input  logic [15:0]          dst_addr,
  input  logic [15:0]          len,
  input  logic                 fill_mode,
  input  logic [7:0]           fill_val,
  output logic                 busy,
  output logic                 done,
  z80_dma_bus_master_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ, ST_RD, ST_CAP, ST_WR, ST_REL, ST_DONE
  } state_t;

  localparam logic [15:0] BURST_L = 16'(BURST);
  // Gap counter starts at 0 in the first release cycle, so compare against REL_GAP-1.
  localparam logic [7:0]  GAP_L   = (REL_GAP > 32'sd0) ? 8'(REL_GAP - 32'sd1) : 8'd0;

  state_t      state_r, state_s, next_byte_s;
  logic [15:0] src_r, src_s, dst_r, dst_s, rem_r, rem_s, burst_r, burst_s;
  logic [7:0]  gap_r, gap_s, data_r, data_s;
  logic        err_r, err_s, busy_r, busy_s, done_r, done_s;
  logic        busrq_n_r, busrq_n_s, bus_oe_r, bus_oe_s;
  logic        mreq_n_r, mreq_n_s, rd_n_r, rd_n_s, wr_n_r, wr_n_s;
  logic [15:0] mem_a_r, mem_a_s;
  logic [7:0]  mem_do_r, mem_do_s;
  logic        tenure_s;

`ifdef Z80_DMA_FILL_EN
  logic        fill_r, fill_s;
  logic [7:0]  fill_val_r, fill_val_s;
  assign next_byte_s = fill_r ? ST_WR : ST_RD;
`else
  logic        unused_fill_s;
  assign unused_fill_s = ^{fill_mode, fill_val};
  assign next_byte_s   = ST_RD;
`endif

  // Next-state, datapath and next-output computation.
  always_comb begin
    state_s = state_r;
    src_s   = src_r;
    dst_s   = dst_r;
    rem_s   = rem_r;
    burst_s = burst_r;
    gap_s   = 8'd0;
    data_s  = data_r;
    err_s   = err_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
`ifdef Z80_DMA_FILL_EN
    fill_s     = fill_r;
    fill_val_s = fill_val_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start && (len != 16'd0)) begin
          state_s = ST_REQ;
          src_s   = src_addr;
          dst_s   = dst_addr;
          rem_s   = len;
          burst_s = 16'd0;
          err_s   = 1'b0;
          busy_s  = 1'b1;
`ifdef Z80_DMA_FILL_EN
          fill_s     = fill_mode;
          fill_val_s = fill_val;
`endif
        end else if (start) begin
          done_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (!bus.busak_n) begin
          state_s = next_byte_s;
          err_s   = 1'b0;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RD: begin
        state_s = ST_CAP;
        if (bus.busak_n) err_s = 1'b1; else err_s = err_r;
      end
      ST_CAP: begin
        state_s = ST_WR;
        data_s  = bus.mem_di;
        if (bus.busak_n) err_s = 1'b1; else err_s = err_r;
      end
      ST_WR: begin
        src_s   = src_r + 16'd1;
        dst_s   = dst_r + 16'd1;
        rem_s   = rem_r - 16'd1;
        burst_s = burst_r + 16'd1;
        err_s   = 1'b0;
        // A lost BUSAK mid-tenure finishes this byte, then re-requests with progress kept.
        if (rem_r == 16'd1) begin
          state_s = ST_DONE;
        end else if (err_r || bus.busak_n) begin
          state_s = ST_REQ;
        end else if ((BURST != 32'sd0) && (burst_s == BURST_L)) begin
          state_s = ST_REL;
        end else begin
          state_s = next_byte_s;
        end
      end
      ST_REL: begin
        if (gap_r != 8'hFF) gap_s = gap_r + 8'd1; else gap_s = gap_r;
        if (bus.busak_n && (gap_r >= GAP_L)) begin
          state_s = ST_REQ;
          burst_s = 16'd0;
        end else begin
          state_s = ST_REL;
        end
      end
      ST_DONE: begin
        if (bus.busak_n) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase

    tenure_s  = (state_s == ST_RD) || (state_s == ST_CAP) || (state_s == ST_WR);
    bus_oe_s  = tenure_s;
    busrq_n_s = !(tenure_s || (state_s == ST_REQ));
    mreq_n_s  = !tenure_s;
    rd_n_s    = !((state_s == ST_RD) || (state_s == ST_CAP));
    wr_n_s    = !(state_s == ST_WR);

    if ((state_s == ST_RD) || (state_s == ST_CAP)) begin
      mem_a_s = src_s;
    end else if (state_s == ST_WR) begin
      mem_a_s = dst_s;
    end else begin
      mem_a_s = mem_a_r;
    end

    if (state_s == ST_WR) begin
`ifdef Z80_DMA_FILL_EN
      mem_do_s = fill_s ? fill_val_s : data_s;
`else
      mem_do_s = data_s;
`endif
    end else begin
      mem_do_s = mem_do_r;
    end
  end

  // State, datapath and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      src_r     <= 16'd0;
      dst_r     <= 16'd0;
      rem_r     <= 16'd0;
      burst_r   <= 16'd0;
      gap_r     <= 8'd0;
      data_r    <= 8'd0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      busrq_n_r <= 1'b1;
      bus_oe_r  <= 1'b0;
      mreq_n_r  <= 1'b1;
      rd_n_r    <= 1'b1;
      wr_n_r    <= 1'b1;
      mem_a_r   <= 16'd0;
      mem_do_r  <= 8'd0;
`ifdef Z80_DMA_FILL_EN
      fill_r     <= 1'b0;
      fill_val_r <= 8'd0;
`endif
    end else begin
      state_r   <= state_s;
      src_r     <= src_s;
      dst_r     <= dst_s;
      rem_r     <= rem_s;
      burst_r   <= burst_s;
      gap_r     <= gap_s;
      data_r    <= data_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      busrq_n_r <= busrq_n_s;
      bus_oe_r  <= bus_oe_s;
      mreq_n_r  <= mreq_n_s;
      rd_n_r    <= rd_n_s;
      wr_n_r    <= wr_n_s;
      mem_a_r   <= mem_a_s;
      mem_do_r  <= mem_do_s;
`ifdef Z80_DMA_FILL_EN
      fill_r     <= fill_s;
      fill_val_r <= fill_val_s;
`endif
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign bus.busrq_n    = busrq_n_r;
  assign bus.bus_oe     = bus_oe_r;
  assign bus.mem_a      = mem_a_r;
  assign bus.mem_do     = mem_do_r;
  assign bus.mem_mreq_n = mreq_n_r;
  assign bus.mem_rd_n   = rd_n_r;
  assign bus.mem_wr_n   = wr_n_r;

endmodule

// File: tb/tb_z80_dma_bus_master.sv
// Scoreboard bench for z80_dma_bus_master: memory and CPU handshake models, directed transfers.
`timescale 1ns/1ps
module tb_z80_dma_bus_master;

  localparam logic [1:0] EV_RD = 2'd0, EV_WR = 2'd1, EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  logic start, fill_mode, sel;
  logic [15:0] src_addr, dst_addr, len;
  logic [7:0] fill_val;
  logic busy0, busy1, done0, done1, start0, start1;
  logic cpu_busak_n;
  logic [7:0] mem_di;
  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  z80_dma_bus_master_if if0 ();
  z80_dma_bus_master_if if1 ();

  assign start0      = start & ~sel;
  assign start1      = start & sel;
  assign if0.busak_n = sel ? 1'b1 : cpu_busak_n;
  assign if1.busak_n = sel ? cpu_busak_n : 1'b1;
  assign if0.mem_di  = mem_di;
  assign if1.mem_di  = mem_di;

  z80_dma_bus_master #(.BURST(0), .REL_GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start0), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_mode(fill_mode), .fill_val(fill_val), .busy(busy0), .done(done0),
    .bus(if0.master)
  );

  z80_dma_bus_master #(.BURST(2), .REL_GAP(2)) dut_b (
    .clk(clk), .reset(reset), .start(start1), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .fill_mode(fill_mode), .fill_val(fill_val), .busy(busy1), .done(done1),
    .bus(if1.master)
  );

  // View of whichever instance currently sits on the bus.
  logic c_busrq_n, c_bus_oe, c_mreq_n, c_rd_n, c_wr_n, c_busy, c_done;
  logic [15:0] c_mem_a;
  logic [7:0] c_mem_do;
  assign c_busrq_n = sel ? if1.busrq_n    : if0.busrq_n;
  assign c_bus_oe  = sel ? if1.bus_oe     : if0.bus_oe;
  assign c_mreq_n  = sel ? if1.mem_mreq_n : if0.mem_mreq_n;
  assign c_rd_n    = sel ? if1.mem_rd_n   : if0.mem_rd_n;
  assign c_wr_n    = sel ? if1.mem_wr_n   : if0.mem_wr_n;
  assign c_mem_a   = sel ? if1.mem_a      : if0.mem_a;
  assign c_mem_do  = sel ? if1.mem_do     : if0.mem_do;
  assign c_busy    = sel ? busy1          : busy0;
  assign c_done    = sel ? done1          : done0;

  int n_checks = 0, n_fail = 0;
  ev_t exp_q[$];
  int pc = 0, ack_dly = 0;
  int rq_falls = 0, oe_cycles = 0, hi_run = 0, min_gap = 1000, m1_miss = 0;
  int pc_at_rel = 0, wr_seen = 0, done_cnt = 0;
  logic prev_rd_n = 1'b1, prev_busrq_n = 1'b1;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h, required no event", kind, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.addr != a || e.data != d) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                 kind, a, d, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Memory (data registered on negedge) and CPU BUSAK/M1 model.
  always @(negedge clk) begin
    if (reset) begin
      cpu_busak_n = 1'b1;
      ack_dly     = 0;
      pc          = 0;
    end else begin
      if (c_bus_oe && !c_mreq_n && !c_wr_n) mem[c_mem_a] = c_mem_do;
      if (cpu_busak_n) pc++;
      if (c_busrq_n) begin
        cpu_busak_n = 1'b1;
        ack_dly     = 0;
      end else if (cpu_busak_n) begin
        if (ack_dly == 2) cpu_busak_n = 1'b0;
        else ack_dly++;
      end
    end
    mem_di = mem[c_mem_a];
  end

  // Monitor: pops the scoreboard on every read start, write cycle and done pulse.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (!c_rd_n && prev_rd_n) begin
        sb_check(EV_RD, c_mem_a, 8'd0);
        check("strobe_own_rd", {30'd0, c_bus_oe, cpu_busak_n}, 32'd2);
      end
      if (!c_wr_n) begin
        sb_check(EV_WR, c_mem_a, c_mem_do);
        check("strobe_own_wr", {30'd0, c_bus_oe, cpu_busak_n}, 32'd2);
        wr_seen++;
      end
      if (c_done) begin
        sb_check(EV_DONE, 16'd0, 8'd0);
        done_cnt++;
      end
      if (c_bus_oe) oe_cycles++;
      if (!c_busrq_n && prev_busrq_n) begin
        rq_falls++;
        if (rq_falls > 1) begin
          if (hi_run < min_gap) min_gap = hi_run;
          if (pc == pc_at_rel) m1_miss++;
        end
      end
      if (c_busrq_n && !prev_busrq_n) pc_at_rel = pc;
      hi_run = c_busrq_n ? hi_run + 1 : 0;
    end
    prev_rd_n    = c_rd_n;
    prev_busrq_n = c_busrq_n;
  end

  task automatic clear_stats();
    rq_falls = 0; oe_cycles = 0; min_gap = 1000; m1_miss = 0; wr_seen = 0; hi_run = 0;
  endtask

  task automatic expect_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++) begin
      exp_q.push_back({EV_RD, s + 16'(i), 8'd0});
      exp_q.push_back({EV_WR, d + 16'(i), mem[s + 16'(i)]});
    end
    exp_q.push_back({EV_DONE, 16'd0, 8'd0});
  endtask

  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                       input logic fm, input logic [7:0] fv);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = n; fill_mode = fm; fill_val = fv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] cp_vals [4];
    int dc;
    cp_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b1; start = 1'b0; sel = 1'b0; fill_mode = 1'b0; fill_val = 8'd0;
    src_addr = 16'd0; dst_addr = 16'd0; len = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    for (int i = 0; i < 4; i++) mem[16'h1000 + 16'(i)] = cp_vals[i];
    mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2; mem[16'h0000] = 8'hC3;
    for (int i = 0; i < 5; i++) mem[16'h3000 + 16'(i)] = 8'h50 + 8'(i);

    repeat (3) @(negedge clk);
    check("rst_busrq_n", {31'd0, if0.busrq_n}, 32'd1);
    check("rst_bus_oe", {31'd0, if0.bus_oe}, 32'd0);
    check("rst_strobes", {29'd0, if0.mem_mreq_n, if0.mem_rd_n, if0.mem_wr_n}, 32'd7);
    check("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
    check("rst_mem_a", {16'd0, if0.mem_a}, 32'd0);
    check("rst_mem_do", {24'd0, if0.mem_do}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Plain copy, single tenure.
    clear_stats();
    expect_copy(16'h1000, 16'h2000, 16'd4);
    issue(16'h1000, 16'h2000, 16'd4, 1'b0, 8'd0);
    check("copy_busy", {31'd0, c_busy}, 32'd1);
    wait_empty("copy", 200);
    check("copy_rq_periods", rq_falls, 32'd1);
    check("copy_oe_cycles", oe_cycles, 32'd12);
    for (int i = 0; i < 4; i++) check("copy_mem", {24'd0, mem[16'h2000 + 16'(i)]}, {24'd0, cp_vals[i]});

    // Source address wraps from 0xFFFF to 0x0000.
    clear_stats();
    expect_copy(16'hFFFE, 16'h8000, 16'd3);
    issue(16'hFFFE, 16'h8000, 16'd3, 1'b0, 8'd0);
    wait_empty("wrap", 200);
    check("wrap_mem2", {24'd0, mem[16'h8002]}, 32'hC3);

    // Bursting instance: BURST=2, len=5 gives three tenures.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    clear_stats();
    expect_copy(16'h3000, 16'h6000, 16'd5);
    issue(16'h3000, 16'h6000, 16'd5, 1'b0, 8'd0);
    wait_empty("burst", 400);
    check("burst_rq_periods", rq_falls, 32'd3);
    check("burst_gap_ge2", {31'd0, (min_gap >= 2)}, 32'd1);
    check("burst_cpu_m1", m1_miss, 32'd0);
    for (int i = 0; i < 5; i++) check("burst_mem", {24'd0, mem[16'h6000 + 16'(i)]}, 32'h50 + i);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    // Zero length: done on the next cycle, no bus request.
    clear_stats();
    exp_q.push_back({EV_DONE, 16'd0, 8'd0});
    issue(16'h1000, 16'h2000, 16'd0, 1'b0, 8'd0);
    check("zero_done_next", {31'd0, c_done}, 32'd1);
    wait_empty("zero", 20);
    check("zero_no_busrq", rq_falls, 32'd0);

    // Second start while busy is ignored.
    clear_stats();
    dc = done_cnt;
    expect_copy(16'h1000, 16'h2100, 16'd2);
    issue(16'h1000, 16'h2100, 16'd2, 1'b0, 8'd0);
    @(negedge clk);
    check("busy_before_2nd", {31'd0, c_busy}, 32'd1);
    issue(16'h3000, 16'h2200, 16'd3, 1'b0, 8'd0);
    wait_empty("busy_start", 200);
    repeat (20) @(negedge clk);
    check("busy_one_done", done_cnt - dc, 32'd1);
    check("busy_2nd_untouched", {24'd0, mem[16'h2200]}, {24'd0, pat(16'h2200)});

    // Reset after the second byte of a six-byte copy.
    clear_stats();
    dc = done_cnt;
    expect_copy(16'h4000, 16'h5000, 16'd6);
    issue(16'h4000, 16'h5000, 16'd6, 1'b0, 8'd0);
    for (int n = 0; n < 200 && wr_seen < 2; n++) begin
      @(posedge clk);
      #2;
    end
    check("rst_mid_reached", {31'd0, (wr_seen >= 2)}, 32'd1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_busrq_n", {31'd0, if0.busrq_n}, 32'd1);
    check("rst_mid_bus_oe", {31'd0, if0.bus_oe}, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", done_cnt - dc, 32'd0);
    for (int i = 0; i < 6; i++)
      check("rst_mid_mem", {24'd0, mem[16'h5000 + 16'(i)]},
            {24'd0, (i < 2) ? pat(16'h4000 + 16'(i)) : pat(16'h5000 + 16'(i))});

    // Fill request; a plain copy when the fill feature is compiled out.
    clear_stats();
`ifdef Z80_DMA_FILL_EN
    for (int i = 0; i < 3; i++) exp_q.push_back({EV_WR, 16'hD8E4 + 16'(i), 8'hB5});
    exp_q.push_back({EV_DONE, 16'd0, 8'd0});
`else
    expect_copy(16'h3000, 16'hD8E4, 16'd3);
`endif
    issue(16'h3000, 16'hD8E4, 16'd3, 1'b1, 8'hB5);
    wait_empty("fill", 200);
`ifdef Z80_DMA_FILL_EN
    check("fill_oe_cycles", oe_cycles, 32'd3);
    for (int i = 0; i < 3; i++) check("fill_mem", {24'd0, mem[16'hD8E4 + 16'(i)]}, 32'hB5);
`else
    check("fill_oe_cycles", oe_cycles, 32'd9);
    for (int i = 0; i < 3; i++) check("fill_mem", {24'd0, mem[16'hD8E4 + 16'(i)]}, 32'h50 + i);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/z80_dma_bus_master.md
Name: z80_dma_bus_master

Overview:
- Secondary bus master for the tv80s-based system.
- Uses the CPU BUSRQ/BUSAK handshake to take the shared 64 KiB memory bus, then performs block copy (or optional fill) transfers.
- Releases the bus back to the CPU between bursts and on completion.
- Sits beside the CPU on the memory mux. The top level steers the memory address/data/strobes from this block whenever bus_oe=1.

Parameters:
- BURST, 0: bytes per bus tenure before a forced release; 0 = whole transfer in one tenure.
- REL_GAP, 2: minimum idle cycles with busrq_n high between tenures.

Ports:
- clk  in  1  system clock; all state changes on posedge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  16  copy source base
- dst_addr  in  16  destination base
- len  in  16  byte count; 0 = no-op
- fill_mode  in  1  1 = fill dst with fill_val (Z80_DMA_FILL_EN only)
- fill_val  in  8  fill byte
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- busrq_n  out  1  to CPU busrq_n
- busak_n  in  1  from CPU busak_n
- bus_oe  out  1  block owns memory bus
- mem_a  out  16  address
- mem_do  out  8  write data
- mem_di  in  8  read data; registered on negedge, so valid at the posedge after the address
- mem_mreq_n, mem_rd_n, mem_wr_n  out  1 each  memory strobes

Behaviour:
- Reset values: busrq_n=1, bus_oe=0, mreq_n=rd_n=wr_n=1, busy=0, done=0, mem_a=0, mem_do=0; state IDLE. Reset mid-transfer abandons it immediately with no done pulse; bytes already written stay written.
- IDLE:
  - start with len≠0 latches src/dst/len/mode, sets busy, and enters REQ.
  - start with len=0 gives a done pulse on the next cycle and never touches busrq_n.
  - start while busy is ignored.
- REQ: busrq_n=0. Wait until busak_n=0 is sampled, then bus_oe=1 from the next cycle and go to RD (copy) or WR (fill).
- Copy, 3 cycles per byte:
  - RD: mem_a=src, mreq_n=rd_n=0.
  - CAP: strobes held; capture mem_di into the data register.
  - WR: mem_a=dst, mem_do=data, mreq_n=wr_n=0.
- Fill, 1 cycle per byte: WR only, mem_do=fill_val.
- After each WR:
  - src+1 and dst+1, modulo 2^16 (0xFFFF wraps to 0x0000); remaining-1; burst count+1.
  - remaining=0 → DONE.
  - BURST≠0 and burst count=BURST → REL.
  - Otherwise the next byte, with no gap cycle.
- REL: bus_oe=0, busrq_n=1, strobes high. Wait until busak_n=1 and REL_GAP cycles have elapsed, reset the burst count, then REQ.
- DONE: same bus release as REL. Once busak_n=1 is sampled, pulse done one cycle, clear busy, and return to IDLE.
- Strobes are only ever low while bus_oe=1 and busak_n=0.
- busak_n rising during a tenure is a CPU protocol error. Finish the current byte, drop bus_oe, and return to REQ with progress kept.

Optional Feature:
- Z80_DMA_FILL_EN defined: fill_mode/fill_val honoured as above.
- Undefined: fill_mode and fill_val ignored; every transfer is a copy, and the fill-path logic is absent.

Test Plan:
- Copy: src=0x1000 = {11,22,33,44}, dst=0x2000, len=4, BURST=0, CPU running NOPs.
  - Expect exactly one busrq_n low period and mem[0x2000..3] = 11,22,33,44.
  - Expect 12 bus-owned cycles and one done pulse; CPU PC advances only outside the tenure.
- Wrap-around: src=0xFFFE, dst=0x8000, len=3. Expect reads from 0xFFFE, 0xFFFF, 0x0000 and writes to 0x8000..0x8002.
- Bursting: BURST=2, len=5 copy. Expect 3 separate busrq_n assertions.
  - Each release has ≥REL_GAP idle cycles and the CPU executes ≥1 M1 between tenures.
  - All 5 bytes are correct.
- Zero length and busy start: len=0 gives a done pulse after 1 cycle with busrq_n never low. A second start while busy is ignored: one done pulse, original parameters used.
- Reset mid-transfer: assert reset after the 2nd byte of a len=6 copy.
  - Expect busrq_n=1, bus_oe=0, no done, bytes 0–1 written and 2–5 untouched.
  - CPU resumes fetch from 0x0000.
- Fill (Z80_DMA_FILL_EN): fill_mode=1, fill_val=0xB5, dst=0xD8E4, len=3. Expect mem[0xD8E4..6] = B5 and 3 write cycles. With the macro undefined, the same stimulus performs a copy.
